// File: rtl/rptr_empty_lvl_pkg.sv
// rptr_empty_lvl_pkg: shared pointer widths and Gray/binary helpers for the dual-clock FIFO
package rptr_empty_lvl_pkg;
  localparam int ADDR_W = 4;
  localparam int PTR_W = ADDR_W + 1;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int k = 1; k < 32; k++) b = b ^ (g >> k);
    return b;
  endfunction
endpackage

// File: rtl/rptr_empty_lvl_if.sv
// rptr_empty_lvl_if: read-side request/status bundle between FIFO reader and pointer block
interface rptr_empty_lvl_if import rptr_empty_lvl_pkg::*; #(parameter int AW = ADDR_W);
  logic          rinc;
  logic          rerr_clr;
  logic [AW:0]   rq2_wptr;
  logic [AW:0]   rae_thresh;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic [AW:0]   rlevel;
  logic          rempty;
  logic          arempty;
  logic          rerr;
  modport master(output rinc, rerr_clr, rq2_wptr, rae_thresh,
                 input raddr, rptr, rlevel, rempty, arempty, rerr);
  modport slave(input rinc, rerr_clr, rq2_wptr, rae_thresh,
                output raddr, rptr, rlevel, rempty, arempty, rerr);
endinterface

// File: rtl/rptr_empty_lvl_gray2bin.sv
// rptr_empty_lvl_gray2bin: combinational Gray-to-binary conversion (XOR prefix from the MSB)
module rptr_empty_lvl_gray2bin #(parameter int WIDTH = 5) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);
  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[WIDTH-1:i];
  end
endmodule

// File: rtl/rptr_empty_lvl.sv
// rptr_empty_lvl: read pointer, empty/almost-empty flags, fill level and sticky underflow
module rptr_empty_lvl import rptr_empty_lvl_pkg::*; #(parameter int ADDRSIZE = ADDR_W) (
  input logic             rclk,
  input logic             rrst_n,
  rptr_empty_lvl_if.slave bus
);
  localparam int PW = ADDRSIZE + 1;
  logic [PW-1:0] r_rbin, r_rptr, r_rlevel;
  logic          r_rempty, r_arempty, r_rerr;
  logic [PW-1:0] w_rbinnext, w_rgraynext, w_wbin, w_lvl_next;
  logic          w_rd, w_uf;
  rptr_empty_lvl_gray2bin #(.WIDTH(PW)) u_g2b (.i_gray(bus.rq2_wptr), .o_bin(w_wbin));
  // flags are derived from the next pointer so they never lag a read
  always_comb begin
    w_rd        = bus.rinc & ~r_rempty;
    w_uf        = bus.rinc & r_rempty;
    w_rbinnext  = r_rbin + PW'(w_rd);
    w_rgraynext = PW'(bin2gray(32'(w_rbinnext)));
    w_lvl_next  = w_wbin - w_rbinnext;
  end
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rbin    <= '0;
      r_rptr    <= '0;
      r_rempty  <= 1'b1;
      r_arempty <= 1'b1;
      r_rlevel  <= '0;
      r_rerr    <= 1'b0;
    end else begin
      r_rbin    <= w_rbinnext;
      r_rptr    <= w_rgraynext;
      r_rempty  <= w_rgraynext == bus.rq2_wptr;
      r_arempty <= w_lvl_next <= bus.rae_thresh;
      r_rlevel  <= w_lvl_next;
      r_rerr    <= w_uf ? 1'b1 : bus.rerr_clr ? 1'b0 : r_rerr;
    end
  end
  assign bus.raddr   = r_rbin[ADDRSIZE-1:0];
  assign bus.rptr    = r_rptr;
  assign bus.rempty  = r_rempty;
  assign bus.arempty = r_arempty;
  assign bus.rlevel  = r_rlevel;
  assign bus.rerr    = r_rerr;
endmodule
